// File: rtl/display_source_selector_pkg.sv
// Shared constants and helpers for the display source selector slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// SEG_BLANK / AN_BLANK / LED_OFF are single-bit fill values; replicate them to bus width.
package disp_pkg;

    localparam logic SEG_BLANK = 1'b1;   // segments are active-low, so blank is all ones
    localparam logic AN_BLANK  = 1'b1;   // anodes are active-low, so blank is all ones
    localparam logic LED_OFF   = 1'b0;   // LEDs are active-high

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/display_source_selector_if.sv
// Bundles the producer-side display buses and the selected board-side outputs.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a level with no handshake.
//
// master: drives src_valid/src_seg/src_an/src_light, observes seg/an/light/sel_idx/none_valid.
// slave : the selector; consumes src_* and drives the selected outputs.
interface display_source_selector_if
    import disp_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SEG_W = 8,
    parameter int AN_W  = 8,
    parameter int LED_W = 16
);
    localparam int SEL_W = clog2(N_SRC);

    logic [N_SRC-1:0]       src_valid;
    logic [N_SRC*SEG_W-1:0] src_seg;
    logic [N_SRC*AN_W-1:0]  src_an;
    logic [N_SRC*LED_W-1:0] src_light;
    logic [SEG_W-1:0]       seg;
    logic [AN_W-1:0]        an;
    logic [LED_W-1:0]       light;
    logic [SEL_W-1:0]       sel_idx;
    logic                   none_valid;

    modport master (
        output src_valid, src_seg, src_an, src_light,
        input  seg, an, light, sel_idx, none_valid
    );

    modport slave (
        input  src_valid, src_seg, src_an, src_light,
        output seg, an, light, sel_idx, none_valid
    );

endinterface

// File: rtl/display_source_selector_key_debounce.sv
// Synchronises and debounces a raw push-button and emits a 1-cycle pulse on an accepted press.
// Latency: 2 sync stages + STABLE_CYC stable samples + 1 register to key_pulse.
// Backpressure: none; a pulse is emitted once and not held.
//
// Ports: fpga_clk, RST (async active-high), key_in (raw), key_level (accepted level),
//        key_pulse (1 cycle on accepted 0->1).
module key_debounce
    import disp_pkg::*;
#(
    parameter int STABLE_CYC = 2_000_000
) (
    input  logic fpga_clk,
    input  logic RST,
    input  logic key_in,
    output logic key_level,
    output logic key_pulse
);
    localparam int               CNT_W   = clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic [CNT_W-1:0] stable_cnt;
    // Set once the button has been seen released and stable. A key held through reset
    // therefore settles its level silently and only a later, fresh press can pulse.
    logic             armed;

    always_ff @(posedge fpga_clk or posedge RST) begin
        if (RST) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_prev  <= 1'b0;
            stable_cnt <= '0;
            armed      <= 1'b0;
            key_level  <= 1'b0;
            key_pulse  <= 1'b0;
        end else begin
            sync_1    <= key_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;

            // Reload on every change of the synced level; saturate once stable.
            if (sync_2 != sync_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end

            key_pulse <= 1'b0;
            if (stable_cnt == CNT_MAX) begin
                key_level <= sync_prev;
                if (!sync_prev) armed <= 1'b1;
                if (sync_prev && !key_level && armed) key_pulse <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_source_selector.sv
// Picks one of N_SRC display producers to drive the board seg/an/light pins.
// Latency: sel_idx moves 1 cycle after an advance event; outputs 1 cycle after sel_idx/src_*.
// Backpressure: none; outputs are registered levels, events are never queued.
//
// Ports: fpga_clk, RST (async active-high), key_next (raw button), auto_en (rotate enable),
//        bus (slave modport: src_valid/src_seg/src_an/src_light in; seg/an/light/sel_idx/none_valid out).
module display_source_selector
    import disp_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int SEG_W        = 8,
    parameter int AN_W         = 8,
    parameter int LED_W        = 16,
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int ROTATE_CYC   = 300_000_000
) (
    input  logic                      fpga_clk,
    input  logic                      RST,
    input  logic                      key_next,
    input  logic                      auto_en,
    display_source_selector_if.slave  bus
);
    localparam int               SEL_W    = clog2(N_SRC);
    localparam int               ROT_W    = clog2(ROTATE_CYC);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYC - 1);

    logic             key_level;
    logic             key_pulse;
    logic             key_step;
    logic [ROT_W-1:0] rot_cnt;
    logic             rot_pulse;
    logic             any_valid;
    logic             cur_valid;
    logic             hunt;
    logic             adv;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] nxt_idx;
    logic [SEG_W-1:0] seg_sel;
    logic [AN_W-1:0]  an_sel;
    logic [LED_W-1:0] light_sel;

    key_debounce #(
        .STABLE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .fpga_clk  (fpga_clk),
        .RST       (RST),
        .key_in    (key_next),
        .key_level (key_level),
        .key_pulse (key_pulse)
    );

    // Pulse and level register together on an accepted press; the level qualifier
    // keeps a release from ever being taken as a step.
    assign key_step = key_pulse & key_level;

    // Rotate timer: a manual step restarts the full period.
    assign rot_pulse = auto_en && (rot_cnt == ROT_LAST);

    always_ff @(posedge fpga_clk or posedge RST) begin
        if (RST) begin
            rot_cnt <= '0;
        end else if (!auto_en || key_step || rot_pulse) begin
            rot_cnt <= '0;
        end else begin
            rot_cnt <= rot_cnt + 1'b1;
        end
    end

    // Current-source slice; constant part-selects keep the mux free of variable offsets.
    always_comb begin
        seg_sel   = '0;
        an_sel    = '0;
        light_sel = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                seg_sel   = bus.src_seg[i*SEG_W +: SEG_W];
                an_sel    = bus.src_an[i*AN_W +: AN_W];
                light_sel = bus.src_light[i*LED_W +: LED_W];
                cur_valid = bus.src_valid[i];
            end
        end
    end

    // Rotated priority search: first valid index after sel_q, wrapping at N_SRC.
    // Holds sel_q when no other source is valid.
    always_comb begin
        int               j;
        logic [SEL_W-1:0] jj;
        logic             found;
        nxt_idx = sel_q;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 1; k < N_SRC; k++) begin
            j = int'(sel_q) + k;
            if (j >= N_SRC) j = j - N_SRC;
            jj = SEL_W'(j);
            if (!found && bus.src_valid[jj]) begin
                nxt_idx = jj;
                found   = 1'b1;
            end
        end
    end

    assign any_valid = |bus.src_valid;
    assign hunt      = any_valid && !cur_valid;
    // All event sources collapse into one advance, so coincident events step once.
    assign adv       = key_step | rot_pulse | hunt;

    always_ff @(posedge fpga_clk or posedge RST) begin
        if (RST) begin
            sel_q          <= '0;
            bus.seg        <= {SEG_W{SEG_BLANK}};
            bus.an         <= {AN_W{AN_BLANK}};
            bus.light      <= {LED_W{LED_OFF}};
            bus.none_valid <= 1'b0;
        end else begin
            if (adv) sel_q <= nxt_idx;
            bus.none_valid <= !any_valid;
            if (!any_valid) begin
                bus.seg   <= {SEG_W{SEG_BLANK}};
                bus.an    <= {AN_W{AN_BLANK}};
                bus.light <= {LED_W{LED_OFF}};
            end else begin
                bus.seg   <= seg_sel;
                bus.an    <= an_sel;
                bus.light <= light_sel;
            end
        end
    end

    assign bus.sel_idx = sel_q;

endmodule

// File: tb/tb_display_source_selector.sv
// Randomised scoreboard bench for display_source_selector (N_SRC=4, fast debounce/rotate).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_display_source_selector;
    import disp_pkg::*;

    localparam int N     = 4;
    localparam int SEG_W = 8;
    localparam int AN_W  = 8;
    localparam int LED_W = 16;
    localparam int DEB   = 4;
    localparam int ROT   = 16;

    logic fpga_clk = 1'b0;
    logic RST      = 1'b0;
    logic key_next = 1'b0;
    logic auto_en  = 1'b0;

    display_source_selector_if #(.N_SRC(N), .SEG_W(SEG_W), .AN_W(AN_W), .LED_W(LED_W)) bus ();

    display_source_selector #(
        .N_SRC(N), .SEG_W(SEG_W), .AN_W(AN_W), .LED_W(LED_W),
        .DEBOUNCE_CYC(DEB), .ROTATE_CYC(ROT)
    ) dut (
        .fpga_clk (fpga_clk),
        .RST      (RST),
        .key_next (key_next),
        .auto_en  (auto_en),
        .bus      (bus)
    );

    always #5 fpga_clk = ~fpga_clk;

    int cyc = 0;
    always @(posedge fpga_clk) cyc <= cyc + 1;

    logic [SEG_W-1:0] seg_tab   [N];
    logic [AN_W-1:0]  an_tab    [N];
    logic [LED_W-1:0] light_tab [N];
    logic [N-1:0]     valid_m;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: expected sel_idx of each step, pushed when stimulus is issued.
    int exp_q[$];
    int model_idx = 0;
    int nsteps    = 0;
    int step_cyc  = 0;
    int last_sel  = 0;
    bit pend      = 1'b0;
    int pend_idx  = 0;
    int mon_e     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference rule: next valid source after cur, wrapping; stay put if none.
    function automatic int ref_next(input int cur, input logic [N-1:0] v);
        for (int k = 1; k < N; k++) begin
            if (v[(cur + k) % N]) return (cur + k) % N;
        end
        return cur;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    task automatic wait_steps(input int target, input int budget, input string nm);
        int t;
        t = 0;
        while (nsteps < target && t < budget) begin
            tick(1);
            t++;
        end
        chk(nm, 32'(nsteps >= target), 32'd1);
    endtask

    task automatic set_valid(input logic [N-1:0] v);
        if (v != '0 && !v[model_idx]) begin
            model_idx = ref_next(model_idx, v);
            exp_q.push_back(model_idx);
        end
        valid_m       = v;
        bus.src_valid = v;
    endtask

    task automatic press();
        int n;
        n = ref_next(model_idx, valid_m);
        if (n != model_idx) exp_q.push_back(n);
        model_idx = n;
        key_next  = 1'b1;
        tick(10);
        key_next  = 1'b0;
        tick(10);
    endtask

    // Monitor: pops an expectation for each sel_idx change and checks the data
    // that follows one cycle later.
    always @(negedge fpga_clk) begin
        if (RST) begin
            last_sel = 0;
            pend     = 1'b0;
        end else begin
            if (pend) begin
                chk("step_seg",   32'(bus.seg),   32'(seg_tab[pend_idx]));
                chk("step_an",    32'(bus.an),    32'(an_tab[pend_idx]));
                chk("step_light", 32'(bus.light), 32'(light_tab[pend_idx]));
                pend = 1'b0;
            end
            if (int'(bus.sel_idx) != last_sel) begin
                nsteps++;
                step_cyc = cyc;
                last_sel = int'(bus.sel_idx);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_step: got sel_idx %0d, want no step (cycle %0d)", last_sel, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("step_idx", 32'(last_sel), 32'(mon_e));
                    pend     = 1'b1;
                    pend_idx = mon_e;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int lat, raise_c, s, t_prev, tp, ta, tc, d;

        for (int i = 0; i < N; i++) begin
            seg_tab[i]   = 8'hC0 + 8'(i);
            an_tab[i]    = 8'($urandom);
            light_tab[i] = 16'($urandom);
            bus.src_seg[i*SEG_W +: SEG_W]   = seg_tab[i];
            bus.src_an[i*AN_W +: AN_W]      = an_tab[i];
            bus.src_light[i*LED_W +: LED_W] = light_tab[i];
        end
        valid_m       = 4'b1111;
        bus.src_valid = 4'b1111;

        // 1. reset values, then first selection
        #1 RST = 1'b1;
        tick(3);
        chk("reset_seg",   32'(bus.seg),        32'hFF);
        chk("reset_an",    32'(bus.an),         32'hFF);
        chk("reset_light", 32'(bus.light),      32'h0);
        chk("reset_sel",   32'(bus.sel_idx),    32'd0);
        chk("reset_none",  32'(bus.none_valid), 32'd0);
        RST = 1'b0;
        tick(8);
        chk("seg_src0",  32'(bus.seg),        32'hC0);
        chk("an_src0",   32'(bus.an),         32'(an_tab[0]));
        chk("none_low",  32'(bus.none_valid), 32'd0);

        // 2. clean press steps once; bounce does not step
        press();
        wait_steps(1, 10, "press_step");
        s = nsteps;
        key_next = 1'b1; tick(1);
        key_next = 1'b0; tick(1);
        key_next = 1'b1; tick(1);
        key_next = 1'b0; tick(15);
        chk("bounce_no_step", 32'(nsteps), 32'(s));

        // 3. skip invalid source and wrap
        set_valid(4'b1011);
        tick(2);
        press();
        press();
        wait_steps(3, 10, "skip_wrap_steps");
        chk("wrap_sel", 32'(bus.sel_idx), 32'(model_idx));

        // randomised masks and presses
        repeat (6) begin
            set_valid(4'($urandom_range(1, 15)));
            tick(3);
            press();
        end
        set_valid(4'b1111);
        tick(3);
        chk("rand_sel", 32'(bus.sel_idx), 32'(model_idx));

        // calibrate press-to-step latency
        s = nsteps;
        exp_q.push_back(ref_next(model_idx, valid_m));
        model_idx = ref_next(model_idx, valid_m);
        key_next  = 1'b1;
        raise_c   = cyc;
        wait_steps(s + 1, 30, "calib_step");
        lat = step_cyc - raise_c;
        tick(5);
        key_next = 1'b0;
        tick(10);

        // 4. auto-rotate period
        for (int k = 0; k < 4; k++) begin
            model_idx = ref_next(model_idx, valid_m);
            exp_q.push_back(model_idx);
        end
        auto_en = 1'b1;
        s = nsteps;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_steps(s + k + 1, 25, "auto_step");
            if (k > 0) chk("auto_period", 32'(step_cyc - t_prev), 32'(ROT));
            t_prev = step_cyc;
        end

        // press mid-period restarts the period
        tick(2);
        s = nsteps;
        press();
        chk("mid_press_one_step", 32'(nsteps), 32'(s + 1));
        tp = step_cyc;
        model_idx = ref_next(model_idx, valid_m);
        exp_q.push_back(model_idx);
        wait_steps(s + 2, 20, "auto_after_press_step");
        chk("auto_after_press", 32'(step_cyc - tp), 32'(ROT));

        // press landing on the terminal count steps exactly once
        ta = step_cyc;
        while (cyc < ta + ROT - lat) tick(1);
        s = nsteps;
        model_idx = ref_next(model_idx, valid_m);
        exp_q.push_back(model_idx);
        key_next = 1'b1;
        raise_c  = cyc;
        wait_steps(s + 1, 20, "coincide_step");
        tc = step_cyc;
        chk("coincide_at_tc", 32'(tc), 32'(ta + ROT));
        while (cyc < raise_c + 10) tick(1);
        key_next = 1'b0;
        model_idx = ref_next(model_idx, valid_m);
        exp_q.push_back(model_idx);
        wait_steps(s + 2, 25, "coincide_next_step");
        chk("coincide_period", 32'(step_cyc - tc), 32'(ROT));
        auto_en = 1'b0;
        tick(3);

        // 5. hunt, none_valid, restore
        for (int k = 0; k < N && model_idx != 2; k++) press();
        chk("at_src2", 32'(bus.sel_idx), 32'd2);
        s = nsteps;
        d = cyc;
        set_valid(4'b1011);
        wait_steps(s + 1, 5, "hunt_step");
        chk("hunt_latency_ok", 32'((step_cyc - d) <= 2), 32'd1);
        tick(2);
        set_valid(4'b0000);
        tick(3);
        chk("none_flag",  32'(bus.none_valid), 32'd1);
        chk("none_seg",   32'(bus.seg),        32'hFF);
        chk("none_an",    32'(bus.an),         32'hFF);
        chk("none_light", 32'(bus.light),      32'h0);
        chk("none_hold",  32'(bus.sel_idx),    32'(model_idx));
        set_valid(4'b0001);
        wait_steps(s + 2, 5, "restore_step");
        tick(2);
        chk("restore_none", 32'(bus.none_valid), 32'd0);
        chk("restore_seg",  32'(bus.seg),        32'hC0);

        // 6. reset mid-debounce and mid-rotate; held key ignored afterwards
        set_valid(4'b1111);
        tick(2);
        press();
        auto_en  = 1'b1;
        key_next = 1'b1;
        tick(3);
        RST = 1'b1;
        #1;
        chk("mid_rst_sel",   32'(bus.sel_idx),    32'd0);
        chk("mid_rst_seg",   32'(bus.seg),        32'hFF);
        chk("mid_rst_an",    32'(bus.an),         32'hFF);
        chk("mid_rst_light", 32'(bus.light),      32'h0);
        chk("mid_rst_none",  32'(bus.none_valid), 32'd0);
        model_idx = 0;
        auto_en   = 1'b0;
        tick(2);
        RST = 1'b0;
        s = nsteps;
        tick(30);
        chk("held_key_no_step", 32'(nsteps), 32'(s));
        chk("held_key_sel",     32'(bus.sel_idx), 32'd0);
        key_next = 1'b0;
        tick(10);
        press();
        chk("post_rst_press_sel", 32'(bus.sel_idx), 32'd1);

        tick(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
